// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared 640x480@60 Hz raster timing for the scanner, the graphics compositor
// and the game FSM. Holds the per-region widths, derived totals, sync window
// bounds, default pixel divider / compositor read latency, the coordinate and
// RGB types, and a small window-membership helper.
package vga_timing_pkg;

  // Pixel clock divider (100 MHz / 4 = 25 MHz) and compositor read latency.
  localparam int VGA_PIX_DIV  = 4;
  localparam int VGA_RD_LAT   = 2;

  // Horizontal timing, in pixels.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Vertical timing, in lines.
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;  // 800
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;  // 525

  // Sync windows are half-open: [start, end).
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;          // 656
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;        // 752
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;          // 490
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;        // 492

  localparam int VGA_CW = 10;

  typedef logic [VGA_CW-1:0] coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // True when c lies in the half-open window [lo, hi).
  function automatic logic in_window(coord_t c, int lo, int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_raster_cnt.sv
// vga_raster_cnt
// Pixel-rate divider plus horizontal/vertical scan counters.
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   h_cnt, v_cnt     current scan position
//   h_nxt, v_nxt     position the counters move to on the next pix_tick
//   pix_tick         high on the last system clock of each pixel period
//   frame_cond       current pixel is the last one of the last active line
module vga_raster_cnt
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV  = VGA_PIX_DIV,
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int V_ACTIVE = VGA_V_ACTIVE
) (
  input  logic   clk,
  input  logic   rst_n,
  output coord_t h_cnt,
  output coord_t v_cnt,
  output coord_t h_nxt,
  output coord_t v_nxt,
  output logic   pix_tick,
  output logic   frame_cond
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          h_wrap;
  logic          v_wrap;

  assign pix_tick   = (div_cnt == DW'(PIX_DIV - 1));
  assign h_wrap     = (h_cnt == coord_t'(H_TOTAL - 1));
  assign v_wrap     = (v_cnt == coord_t'(V_TOTAL - 1));

  // Line wrap and frame wrap resolve together: (H_TOTAL-1, V_TOTAL-1) -> (0,0).
  assign h_nxt      = h_wrap ? '0 : h_cnt + 1'b1;
  assign v_nxt      = !h_wrap ? v_cnt : (v_wrap ? '0 : v_cnt + 1'b1);

  // Leaving the final pixel of the last active line: vertical blanking begins.
  assign frame_cond = h_wrap && (v_cnt == coord_t'(V_ACTIVE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pix_tick ? '0 : div_cnt + 1'b1;
      if (pix_tick) begin
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
      end
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
// VGA raster scanner and pixel fetcher in front of the graphics compositor.
// Presents the scan coordinate to graphics, captures the returned RGB at the
// end of each pixel period and drives blanked RGB, active-low syncs, an
// active flag and a once-per-frame tick.
// Ports:
//   clk, rst_n               system clock, async active-low reset
//   i_r, i_g, i_b            RGB from graphics for o_x_read/o_y_read
//   o_x_read, o_y_read       current scan coordinate (unclamped in blanking)
//   o_r, o_g, o_b            pin RGB, zero outside the active area
//   o_hs, o_vs               active-low sync
//   o_active                 pixel on the pins is inside the active area
//   o_frame_tick             one-clock pulse entering vertical blanking
// Pin outputs trail o_x_read/o_y_read by one pixel period; they all come from
// the same register stage so they stay mutually aligned.
// Graphics RGB is only sampled at the end of a pixel period, so RD_LAT must be
// smaller than PIX_DIV for the compositor output to have settled.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV  = VGA_PIX_DIV,
  parameter int RD_LAT   = VGA_RD_LAT,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_r,
  input  logic [3:0] i_g,
  input  logic [3:0] i_b,
  output logic [9:0] o_x_read,
  output logic [9:0] o_y_read,
  output logic [3:0] o_r,
  output logic [3:0] o_g,
  output logic [3:0] o_b,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_active,
  output logic       o_frame_tick
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  generate
    if (RD_LAT >= PIX_DIV || H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_param_check
      $error("vga_scan_ctrl: RD_LAT must be < PIX_DIV and totals must fit 10 bits");
    end
  endgenerate

  coord_t h_cnt;
  coord_t v_cnt;
  coord_t h_nxt;
  coord_t v_nxt;
  logic   pix_tick;
  logic   frame_cond;
  logic   pix_active;
  rgb_t   pin_rgb;

  vga_raster_cnt #(
    .PIX_DIV  (PIX_DIV),
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .h_nxt      (h_nxt),
    .v_nxt      (v_nxt),
    .pix_tick   (pix_tick),
    .frame_cond (frame_cond)
  );

  // Classification of the pixel whose period is ending on this pix_tick.
  assign pix_active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_x_read     <= '0;
      o_y_read     <= '0;
      pin_rgb      <= '0;
      o_hs         <= 1'b1;
      o_vs         <= 1'b1;
      o_active     <= 1'b0;
      o_frame_tick <= 1'b0;
    end else begin
      o_frame_tick <= pix_tick && frame_cond;
      if (pix_tick) begin
        // Coordinate registers load the counters' next value so they track
        // h_cnt/v_cnt exactly and hold each value for PIX_DIV clocks.
        o_x_read <= h_nxt;
        o_y_read <= v_nxt;
        // Capture stage: the ending pixel moves onto the pins.
        pin_rgb  <= pix_active ? rgb_t'({i_r, i_g, i_b}) : '0;
        o_hs     <= !in_window(h_cnt, HS_START, HS_END);
        o_vs     <= !in_window(v_cnt, VS_START, VS_END);
        o_active <= pix_active;
      end
    end
  end

  assign o_r = pin_rgb.r;
  assign o_g = pin_rgb.g;
  assign o_b = pin_rgb.b;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl
// Two scanners run side by side from one clock and reset: instance 0 with the
// real 640x480 timing (line-level behaviour), instance 1 with a tiny raster so
// whole frames fit in a short run. Each is checked every cycle against a model
// that derives every output from the number of clocks since reset release.
module tb_vga_scan_ctrl;

  // Per-instance timing: index 0 = 640x480@60, index 1 = miniature raster.
  localparam int CP [2] = '{4, 3};
  localparam int CHA[2] = '{640, 8};
  localparam int CHF[2] = '{16, 2};
  localparam int CHS[2] = '{96, 3};
  localparam int CHB[2] = '{48, 2};
  localparam int CVA[2] = '{480, 6};
  localparam int CVF[2] = '{10, 1};
  localparam int CVS[2] = '{2, 2};
  localparam int CVB[2] = '{33, 1};

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [9:0]  xr [2];
  logic [9:0]  yr [2];
  logic [3:0]  pr [2];
  logic [3:0]  pg [2];
  logic [3:0]  pb [2];
  logic        hs [2];
  logic        vs [2];
  logic        act[2];
  logic        ft [2];
  logic [11:0] i_rgb [2];
  logic [11:0] g1    [2];
  logic [11:0] g2    [2];
  logic [11:0] rnd   [2];
  logic [11:0] last_i[2];
  int          t     [2];
  int          mode;   // 0: coordinate pattern, 1: constant white, 2: random

  vga_scan_ctrl #(
    .PIX_DIV(4), .RD_LAT(2),
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_r(i_rgb[0][11:8]), .i_g(i_rgb[0][7:4]), .i_b(i_rgb[0][3:0]),
    .o_x_read(xr[0]), .o_y_read(yr[0]),
    .o_r(pr[0]), .o_g(pg[0]), .o_b(pb[0]),
    .o_hs(hs[0]), .o_vs(vs[0]), .o_active(act[0]), .o_frame_tick(ft[0])
  );

  vga_scan_ctrl #(
    .PIX_DIV(3), .RD_LAT(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_r(i_rgb[1][11:8]), .i_g(i_rgb[1][7:4]), .i_b(i_rgb[1][3:0]),
    .o_x_read(xr[1]), .o_y_read(yr[1]),
    .o_r(pr[1]), .o_g(pg[1]), .o_b(pb[1]),
    .o_hs(hs[1]), .o_vs(vs[1]), .o_active(act[1]), .o_frame_tick(ft[1])
  );

  // ---------------- graphics model ----------------
  function automatic logic [11:0] pat(logic [9:0] x, logic [9:0] y);
    return {x[3:0], y[3:0], 4'h5};
  endfunction

  // Two-clock read latency from coordinate to RGB.
  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      g1[n] <= pat(xr[n], yr[n]);
      g2[n] <= g1[n];
    end
  end

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) rnd[n] = 12'($urandom);
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      i_rgb[n] = (mode == 1) ? 12'hFFF : (mode == 2) ? rnd[n] : g2[n];
    end
  end

  // ---------------- reference timebase ----------------
  // t = system clocks since reset release; last_i = compositor value present
  // on the clock edge that ends each pixel period.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        t[n]      <= 0;
        last_i[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        t[n] <= t[n] + 1;
        if ((t[n] + 1) % CP[n] == 0) last_i[n] <= i_rgb[n];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rel_cyc = 0;
  int last_fall0 = -1;
  int last_tick1 = -1;
  logic prev_hs0 = 1'b1;

  task automatic chk(input string nm, input int n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s inst%0d cyc=%0d got=0x%0h exp=0x%0h", nm, n, cyc, got, exp);
    end
  endtask

  task automatic model_check(input int n);
    int p, ht, vt, tot, k, m, hm, vm, hs0, vs0;
    logic        e_act, e_hs, e_vs, e_ft;
    logic [11:0] e_rgb;
    p   = CP[n];
    ht  = CHA[n] + CHF[n] + CHS[n] + CHB[n];
    vt  = CVA[n] + CVF[n] + CVS[n] + CVB[n];
    tot = ht * vt;
    hs0 = CHA[n] + CHF[n];
    vs0 = CVA[n] + CVF[n];
    k   = t[n] / p;            // pixel periods completed since release
    if (k == 0) begin
      e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0;
    end else begin
      m  = (k - 1) % tot;      // pixel now shown on the pins
      hm = m % ht;
      vm = m / ht;
      e_act = (hm < CHA[n]) && (vm < CVA[n]);
      e_hs  = !((hm >= hs0) && (hm < hs0 + CHS[n]));
      e_vs  = !((vm >= vs0) && (vm < vs0 + CVS[n]));
      if (!e_act)         e_rgb = '0;
      else if (mode == 0) e_rgb = pat(10'(hm), 10'(vm));
      else if (mode == 1) e_rgb = 12'hFFF;
      else                e_rgb = last_i[n];
    end
    e_ft = (t[n] > 0) && (t[n] % p == 0) && ((k % tot) == CVA[n] * ht);
    chk("x_read", n, 32'(xr[n]), 32'(k % ht));
    chk("y_read", n, 32'(yr[n]), 32'((k / ht) % vt));
    chk("rgb", n, 32'({pr[n], pg[n], pb[n]}), 32'(e_rgb));
    chk("hs", n, 32'(hs[n]), 32'(e_hs));
    chk("vs", n, 32'(vs[n]), 32'(e_vs));
    chk("active", n, 32'(act[n]), 32'(e_act));
    chk("frame_tick", n, 32'(ft[n]), 32'(e_ft));
  endtask

  // Hand-computed expectations taken directly from the timing numbers.
  task automatic literal_check();
    if (!rst_n) begin
      last_fall0 = -1;
      last_tick1 = -1;
    end else begin
      if (cyc - rel_cyc == 3)    chk("x0_before_first_inc", 0, 32'(xr[0]), 32'd0);
      if (cyc - rel_cyc == 4)    chk("x0_first_inc", 0, 32'(xr[0]), 32'd1);
      if (cyc - rel_cyc == 3)    chk("x1_first_inc", 1, 32'(xr[1]), 32'd1);
      if (cyc - rel_cyc == 3199) chk("y0_before_line1", 0, 32'(yr[0]), 32'd0);
      if (cyc - rel_cyc == 3200) chk("y0_line1", 0, 32'(yr[0]), 32'd1);
      if (prev_hs0 && !hs[0]) begin
        chk("hs_fall_x", 0, 32'(xr[0]), 32'd657);
        if (last_fall0 >= 0) chk("hs_period", 0, 32'(cyc - last_fall0), 32'd3200);
        last_fall0 = cyc;
      end
      if (!prev_hs0 && hs[0] && last_fall0 >= 0)
        chk("hs_low_width", 0, 32'(cyc - last_fall0), 32'd384);
      if (ft[1]) begin
        chk("ft_y", 1, 32'(yr[1]), 32'd6);
        chk("ft_x", 1, 32'(xr[1]), 32'd0);
        if (last_tick1 >= 0) chk("ft_period", 1, 32'(cyc - last_tick1), 32'd450);
        else                 chk("ft_first", 1, 32'(cyc - rel_cyc), 32'd270);
        last_tick1 = cyc;
      end
    end
    prev_hs0 = hs[0];
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      model_check(0);
      model_check(1);
      literal_check();
    end
  endtask

  task automatic do_reset(input int clocks, input int new_mode);
    #1 rst_n = 1'b0;
    mode = new_mode;
    step(clocks);
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_coord(input int n, input int x, input int y, input int budget);
    int waited = 0;
    while (!(xr[n] == 10'(x) && yr[n] == 10'(y)) && waited < budget) begin
      step(1);
      waited++;
    end
    checks++;
    if (waited >= budget) begin
      errors++;
      $display("FAIL wait_coord inst%0d never reached (%0d,%0d) got=(%0d,%0d)", n, x, y, xr[n], yr[n]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mode = 0;
    step(10);
    chk("reset_rgb", 0, 32'({pr[0], pg[0], pb[0]}), 32'd0);
    chk("reset_hs", 0, 32'(hs[0]), 32'd1);
    chk("reset_vs", 0, 32'(vs[0]), 32'd1);
    chk("reset_x", 0, 32'(xr[0]), 32'd0);
    chk("reset_y", 0, 32'(yr[0]), 32'd0);
    rst_n   = 1'b1;
    rel_cyc = cyc;

    // Coordinate pattern: alignment, sync windows, frame ticks.
    step(10000);

    // Constant white: blanking must zero every inactive pixel.
    do_reset(3, 1);
    step(4000);

    // Random compositor data.
    do_reset(3, 2);
    step(3000);

    // Mid-frame reset on both rasters, then restart from (0,0).
    mode = 0;
    wait_coord(1, 5, 4, 2000);
    do_reset(3, 0);
    step(600);
    wait_coord(0, 320, 0, 4000);
    do_reset(3, 0);
    step(1500);

    // Randomly placed resets of random length.
    repeat (4) begin
      step($urandom_range(50, 1200));
      do_reset($urandom_range(1, 5), $urandom_range(0, 2));
      step(700);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

VGA raster scanner and pixel fetcher that sits in front of the `graphics` compositor. It generates 640x480@60 Hz timing from the 100 MHz system clock. It presents the current scan coordinate to `graphics` and captures the returned RGB after the compositor's fixed read latency. It then drives blanked, sync-aligned RGB, HSYNC and VSYNC to the board pins, plus a once-per-frame tick for game logic.

## Interface
- `PIX_DIV`, 4: system clocks per pixel (100 MHz → 25 MHz pixel rate).
- `RD_LAT`, 2: clocks from coordinate change to valid `graphics` RGB; must satisfy `RD_LAT < PIX_DIV`.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing in lines.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_r`, `i_g`, `i_b`  in  4 each  RGB returned by `graphics` for `o_x_read`/`o_y_read`.
- `o_x_read`  out  10  current horizontal scan count, fed to `graphics`.
- `o_y_read`  out  10  current vertical scan count, fed to `graphics`.
- `o_r`, `o_g`, `o_b`  out  4 each  pin RGB; zero outside the active area.
- `o_hs`, `o_vs`  out  1 each  sync outputs, active-low.
- `o_active`  out  1  high while the pixel currently on the pins is in the active area.
- `o_frame_tick`  out  1  one-clock pulse at the start of vertical blanking.

## Operation
- Derived totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800) and `V_TOTAL` (525). Both must be ≤ 1023 to fit 10 bits.
- Divider `div_cnt` counts 0..PIX_DIV-1 and wraps. `pix_tick = (div_cnt == PIX_DIV-1)`.
- On `pix_tick`:
  - `h_cnt` increments, wrapping `H_TOTAL-1` → 0.
  - On that wrap `v_cnt` increments, wrapping `V_TOTAL-1` → 0.
  - Line wrap and frame wrap happen on the same tick at (799,524) → (0,0).
- `o_x_read = h_cnt` and `o_y_read = v_cnt`, registered, so each value is held for exactly PIX_DIV clocks. Values are not clamped during blanking.
- Capture stage on `pix_tick`, operating on the pixel whose coordinates are ending:
  - `{o_r,o_g,o_b} <= active ? {i_r,i_g,i_b} : 12'h000`.
  - `o_hs <= !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC))`, i.e. low for 656..751.
  - `o_vs <= !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC))`, i.e. low for lines 490..491.
  - `o_active <= (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)`.
- `o_frame_tick` is asserted for one clock when `pix_tick` occurs with `h_cnt == H_TOTAL-1` and `v_cnt == V_ACTIVE-1`, i.e. entering line 480. It never coincides with an active pixel on the pins.

## Timing
- Reset values: `div_cnt`, `h_cnt`, `v_cnt` = 0; `o_x_read`, `o_y_read` = 0; RGB = 0; `o_hs` = `o_vs` = 1; `o_active` = 0; `o_frame_tick` = 0.
- Reset asserted mid-frame clears all state immediately. After release, scanning restarts at (0,0) with the first `pix_tick` PIX_DIV clocks later.
- Pin latency: all pin outputs (RGB, `o_hs`, `o_vs`, `o_active`) lag `o_x_read`/`o_y_read` by exactly one pixel period (PIX_DIV clocks). Because they share a register stage, they remain mutually aligned.
- RGB is sampled PIX_DIV-1 clocks after the coordinate changes, which is ≥ RD_LAT, so the `graphics` output has settled.
- Line period is `H_TOTAL*PIX_DIV` = 3200 clocks. Frame period is 1,680,000 clocks.

## Structure
- Package `vga_timing_pkg` holds the 640x480@60 timing constants, the derived totals, the sync window bounds and `PIX_DIV`/`RD_LAT` defaults. The package is shared with `graphics` and the game FSM.
- One sub-module, `vga_raster_cnt`: divider plus h/v counters. It outputs `h_cnt`, `v_cnt`, `pix_tick` and the frame-tick condition.
- The top level holds the coordinate registers and the capture/blanking/sync stage.

## Test plan
- Reset: hold `rst_n` = 0 for 10 clocks → RGB = 0, `o_hs` = `o_vs` = 1, `o_x_read` = `o_y_read` = 0. The first `o_x_read` increment occurs 4 clocks after release.
- HSYNC: run 2 lines → `o_hs` low for 384 clocks per line, falling edge 3200 clocks apart. The falling edge occurs one pixel (4 clocks) after `o_x_read` = 656.
- VSYNC/frame tick: run 2 frames → `o_vs` low for 6400 clocks starting at line 490. `o_frame_tick` pulses once per 1,680,000 clocks, one clock wide, as `o_y_read` goes 479 → 480.
- Pixel alignment: model `graphics` as a 2-clock delay of `{x[3:0], y[3:0], 4'h5}` → each active pin pixel equals the model value for the previous `o_x_read`/`o_y_read`. There are no off-by-one errors at x = 0, x = 639, y = 0 or y = 479.
- Blanking: drive `i_rgb` = 12'hFFF constantly → `o_rgb` = 12'h000 whenever `o_active` = 0, and 12'hFFF otherwise.
- Mid-frame reset: assert `rst_n` at (x=320, y=200) for 3 clocks → outputs return to reset values. The next frame starts at (0,0) and the first `o_frame_tick` arrives 480 lines later.
